// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises bytes onto an idle-high line with a one-deep holding register for gapless frames
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 txd,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY_ST, STOP} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [2:0]           idx, idx_n;
    logic [DATA_BITS-1:0] sh, sh_n, hold;
    logic                 par, par_n, txd_n, hold_full, rst_q, load, tick, take, hold_par;

    assign tick     = cnt == CMAX;
    assign take     = valid && ready;
    assign hold_par = (PARITY == 1) ? ~^hold : ^hold;
    assign ready    = ~hold_full && ~rst_q;
    assign busy     = (state != IDLE) || hold_full;

    // next-state, bit timing and the registered value of the serial line
    always_comb begin
        state_n = state;
        cnt_n   = tick ? '0 : cnt + 1'b1;
        idx_n   = idx;
        sh_n    = sh;
        par_n   = par;
        txd_n   = txd;
        load    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                txd_n = 1'b1;
                load  = hold_full;
            end
            START: if (tick) begin
                state_n = DATA;
                idx_n   = '0;
                txd_n   = sh[0];
            end
            DATA: if (tick) begin
                if (idx == 3'(DATA_BITS - 1)) begin
                    state_n = (PARITY != 0) ? PARITY_ST : STOP;
                    idx_n   = '0;
                    txd_n   = (PARITY != 0) ? par : 1'b1;
                end else begin
                    idx_n = idx + 3'd1;
                    sh_n  = sh >> 1;
                    txd_n = sh[1];
                end
            end
            PARITY_ST: if (tick) begin
                state_n = STOP;
                idx_n   = '0;
                txd_n   = 1'b1;
            end
            STOP: if (tick) begin
                if (idx == 3'(STOP_BITS - 1)) begin
                    state_n = IDLE;
                    txd_n   = 1'b1;
                    load    = hold_full;
                end else begin
                    idx_n = idx + 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            state_n = START;
            sh_n    = hold;
            par_n   = hold_par;
            txd_n   = 1'b0;
            cnt_n   = '0;
        end
    end

    // frame state, shifter and holding register; reset drops any byte in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            par       <= 1'b0;
            txd       <= 1'b1;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            sh        <= sh_n;
            par       <= par_n;
            txd       <= txd_n;
            hold_full <= take || (hold_full && ~load);
            if (take) hold <= data;
        end
    end

    // delayed reset keeps ready low for the cycle after reset is released
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: scoreboard bench over four parameterisations of uart_transmitter
module tb_uart_transmitter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data [4];
    logic [3:0] valid;
    logic [3:0] ready, txd, busy;
    logic       q[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .data(data[0]), .valid(valid[0]), .ready(ready[0]), .txd(txd[0]), .busy(busy[0]));
    uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .data(data[1]), .valid(valid[1]), .ready(ready[1]), .txd(txd[1]), .busy(busy[1]));
    uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .data(data[2]), .valid(valid[2]), .ready(ready[2]), .txd(txd[2]), .busy(busy[2]));
    uart_transmitter #(.CLKS_PER_BIT(434), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .data(data[3]), .valid(valid[3]), .ready(ready[3]), .txd(txd[3]), .busy(busy[3]));

    task automatic push_frame(input logic [7:0] b, input int par, input int stops);
        q.push_back(1'b0);
        for (int k = 0; k < 8; k++) q.push_back(b[k]);
        if (par == 1) q.push_back(~^b);
        if (par == 2) q.push_back(^b);
        for (int k = 0; k < stops; k++) q.push_back(1'b1);
    endtask

    task automatic drive(input int i, input logic [7:0] b);
        int n = 0;
        while (ready[i] !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready[i] !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait inst%0d ready=%b expected 1", i, ready[i]);
        end
        data[i]  = b;
        valid[i] = 1'b1;
        @(negedge clk);
        valid[i] = 1'b0;
        data[i]  = ~b;
    endtask

    task automatic monitor(input int i, input int c, output int cycles);
        int n = 0;
        int bitn = 0;
        logic e, ok, act;
        cycles = 0;
        while (txd[i] !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (txd[i] !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL start_timeout inst%0d txd=%b expected 0", i, txd[i]);
            q.delete();
            return;
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            ok = 1'b1;
            act = e;
            for (int k = 0; k < c; k++) begin
                if (txd[i] !== e) begin
                    ok = 1'b0;
                    act = txd[i];
                end
                cycles++;
                @(negedge clk);
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL line_bit%0d inst%0d txd=%b expected %b", bitn, i, act, e);
            end
            bitn++;
        end
        checks++;
        if (txd[i] !== 1'b1 || busy[i] !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_frame inst%0d txd=%b busy=%b expected 1 0", i, txd[i], busy[i]);
        end
    endtask

    task automatic test_reset();
        logic ok = 1'b1;
        checks++;
        if (txd[0] !== 1'b1 || ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state txd=%b ready=%b busy=%b expected 1 0 0", txd[0], ready[0], busy[0]);
        end
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (txd[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_20 txd=%b ready=%b busy=%b expected 1 1 0", txd[0], ready[0], busy[0]);
        end
    endtask

    task automatic test_a5();
        int cyc;
        fork
            begin
                data[0]  = 8'hA5;
                valid[0] = 1'b1;
                push_frame(8'hA5, 0, 1);
                @(negedge clk);
                valid[0] = 1'b0;
                data[0]  = 8'h00;
                checks++;
                if (txd[0] !== 1'b1 || ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL accept_cycle txd=%b ready=%b busy=%b expected 1 0 1", txd[0], ready[0], busy[0]);
                end
                @(negedge clk);
                checks++;
                if (txd[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL start_latency txd=%b expected 0", txd[0]);
                end
            end
            monitor(0, 4, cyc);
        join
        checks++;
        if (cyc != 40) begin
            errors++;
            $display("FAIL a5_frame_len cycles=%0d expected 40", cyc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int n = 0;
        fork
            begin
                data[0]  = 8'h3C;
                valid[0] = 1'b1;
                push_frame(8'h3C, 0, 1);
                @(negedge clk);
                checks++;
                if (ready[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_hold_full ready=%b expected 0", ready[0]);
                end
                data[0] = 8'hC3;
                push_frame(8'hC3, 0, 1);
                while (ready[0] !== 1'b1 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (ready[0] !== 1'b1 || busy[0] !== 1'b1 || txd[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL second_accept ready=%b busy=%b txd=%b expected 1 1 0", ready[0], busy[0], txd[0]);
                end
                @(negedge clk);
                valid[0] = 1'b0;
                data[0]  = 8'h00;
                checks++;
                if (ready[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_second_held ready=%b expected 0", ready[0]);
                end
            end
            monitor(0, 4, cyc);
        join
        checks++;
        if (cyc != 80) begin
            errors++;
            $display("FAIL b2b_len cycles=%0d expected 80", cyc);
        end
    endtask

    task automatic test_parity();
        int cyc;
        fork
            begin
                push_frame(8'h07, 2, 1);
                drive(1, 8'h07);
            end
            monitor(1, 4, cyc);
        join
        checks++;
        if (cyc != 44) begin
            errors++;
            $display("FAIL even_len cycles=%0d expected 44", cyc);
        end
        fork
            begin
                push_frame(8'h07, 1, 1);
                drive(2, 8'h07);
            end
            monitor(2, 4, cyc);
        join
        checks++;
        if (cyc != 44) begin
            errors++;
            $display("FAIL odd_len cycles=%0d expected 44", cyc);
        end
    endtask

    task automatic test_mid_reset();
        int cyc;
        int n = 0;
        logic ok = 1'b1;
        drive(0, 8'hFF);
        while (txd[0] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (16) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset txd=%b busy=%b ready=%b expected 1 0 0", txd[0], busy[0], ready[0]);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset ready=%b expected 1", ready[0]);
        end
        for (int k = 0; k < 20; k++) begin
            if (txd[0] !== 1'b1 || busy[0] !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL no_tail_bits txd=%b busy=%b expected 1 0", txd[0], busy[0]);
        end
        fork
            begin
                push_frame(8'h00, 0, 1);
                drive(0, 8'h00);
            end
            monitor(0, 4, cyc);
        join
        checks++;
        if (cyc != 40) begin
            errors++;
            $display("FAIL clean_frame_len cycles=%0d expected 40", cyc);
        end
    endtask

    task automatic test_slow_two_stop();
        int cyc;
        fork
            begin
                push_frame(8'h55, 0, 2);
                drive(3, 8'h55);
                push_frame(8'hAA, 0, 2);
                drive(3, 8'hAA);
            end
            monitor(3, 434, cyc);
        join
        checks++;
        if (cyc != 2 * 11 * 434) begin
            errors++;
            $display("FAIL slow_len cycles=%0d expected %0d", cyc, 2 * 11 * 434);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) data[i] = 8'h00;
        valid = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_a5();
        test_back_to_back();
        test_parity();
        test_mid_reset();
        test_slow_two_stop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
